// File: rtl/mux_pkg.sv
// Shared definitions for the mux skid stage.
//   DEFAULT_WIDTH : default data word width
//   state_e       : occupancy state, encoded as {main_valid, skid_valid}
//   sat_sel()     : saturating select, out-of-range selects map to the last input
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Bit 1 is main_valid, bit 0 is skid_valid, so outputs decode straight from the register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    function automatic int unsigned sat_sel(input int unsigned sel, input int unsigned num_in);
        return (sel >= num_in - 1) ? num_in - 1 : sel;
    endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Pure combinational NUM_IN-way word select with saturating select.
//   sel_i  : raw select
//   data_i : packed inputs, input k at [k*WIDTH +: WIDTH]
//   data_o : selected word (bit-exact)
//   sel_o  : effective (saturated) select
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]        sel_o
);

    int unsigned w_eff;

    assign w_eff  = sat_sel(32'(sel_i), NUM_IN);
    assign sel_o  = SEL_W'(w_eff);
    assign data_o = data_i[w_eff*WIDTH +: WIDTH];

endmodule

// File: rtl/mux_skid_stage.sv
// N-way select stage with registered output and a 2-entry skid buffer.
// Decouples producer and consumer with valid/ready; in_ready_o comes from
// a register only, so stalls never ripple combinationally upstream.
//   clk_i, rst_i (async, active-low)
//   in_valid_i / in_ready_o  : producer handshake
//   sel_i, data_i            : select and packed inputs
//   out_valid_o / out_ready_i: consumer handshake
//   out_data_o, out_sel_o    : registered word and effective select
//   err_o                    : sticky out-of-range select flag
// Optional: define MUX_SKID_SELCHK_EN to enable err_o; otherwise it is tied low.
module mux_skid_stage
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    err_o
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_main_data;
    logic [SEL_W-1:0] r_main_sel;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_sel;

    logic [WIDTH-1:0] w_sel_data;
    logic [SEL_W-1:0] w_sel_eff;
    logic             w_accept;
    logic             w_emit;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Select happens before the registers, so the skid holds post-select data.
    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (w_sel_data),
        .sel_o  (w_sel_eff)
    );

    assign out_valid_o = r_state[1];
    assign in_ready_o  = ~r_state[0];
    assign out_data_o  = r_main_data;
    assign out_sel_o   = r_main_sel;

    assign w_accept = in_valid_i & in_ready_o;
    assign w_emit   = out_valid_o & out_ready_i;

    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next = ONE;
                    w_load_main  = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_emit) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_next = FULL;
                    w_load_skid  = 1'b1;
                end else if (w_emit) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_emit) begin
                    w_state_next     = ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_main) begin
                r_main_data <= w_main_from_skid ? r_skid_data : w_sel_data;
                r_main_sel  <= w_main_from_skid ? r_skid_sel : w_sel_eff;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_sel  <= w_sel_eff;
            end
        end
    end

`ifdef MUX_SKID_SELCHK_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_accept && (32'(sel_i) > NUM_IN - 1)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/mux_skid_stage.md
Name: mux_skid_stage

Overview:
- Parametrised N-way select stage with a registered output and a 2-entry skid buffer.
- Picks one of NUM_IN words per transfer. Out-of-range selects saturate to the last input.
- Decouples producer and consumer with valid/ready handshakes, so pipeline forwarding and writeback selection can be registered without breaking stall propagation.
- Sits between the hazard/forwarding logic and the next pipeline register in the CPU datapath.

Parameters:
- WIDTH, 32, bit width of each data input and of the output word.
- NUM_IN, 4, number of selectable inputs (minimum 2). SEL_W = $clog2(NUM_IN) is a derived localparam, not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid_i  input  1  producer has a transfer.
- in_ready_o  output  1  stage can accept a transfer.
- sel_i  input  SEL_W  input select.
- data_i  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid_o  output  1  out_data_o/out_sel_o hold a valid word.
- out_ready_i  input  1  consumer accepts the word.
- out_data_o  output  WIDTH  selected word, registered.
- out_sel_o  output  SEL_W  effective (saturated) select used for out_data_o.
- err_o  output  1  sticky out-of-range-select flag (see Optional Feature).

Behaviour:
- Select rule: eff_sel = (sel_i >= NUM_IN-1) ? NUM_IN-1 : sel_i. For NUM_IN=3, sel 2 and sel 3 both pick input 2.
- Data is passed bit-exact; no sign handling or extension.
- Accept occurs when in_valid_i && in_ready_o. Emit occurs when out_valid_o && out_ready_i.
- in_ready_o = !skid_valid. It is driven from a register only; there is no combinational path from out_ready_i.
- Latency: a word accepted in cycle t appears on out_data_o in cycle t+1, provided the main register is empty or emitting in cycle t.
- States, encoded as main_valid/skid_valid:
  - EMPTY: accept -> ONE (word loads main).
  - ONE:
    - accept & emit -> ONE (main reloads).
    - accept & !emit -> FULL (word loads skid).
    - !accept & emit -> EMPTY.
    - otherwise hold.
  - FULL: in_ready_o=0. Emit -> ONE (skid moves to main the same edge). No emit -> hold.
- While out_valid_o=1 && out_ready_i=0, out_data_o and out_sel_o are stable.
- Ordering is strict FIFO; no word is dropped or duplicated.
- in_valid_i while in_ready_o=0 is ignored. The producer holds it.
- Reset (async assert, any state, including mid-transfer):
  - out_valid_o=0, out_data_o=0, out_sel_o=0, err_o=0, skid cleared.
  - in_ready_o=1 from reset assertion onward.
- Reset deassertion is synchronised externally; no transfer occurs in the deasserting cycle.

Optional Feature:
- Macro MUX_SKID_SELCHK_EN.
- Defined: err_o sets on the clock edge of any accept with sel_i > NUM_IN-1 and stays set until reset. Data behaviour is unchanged (still saturates).
- Undefined: err_o is tied to 0 and there is no checking logic.
- For power-of-two NUM_IN, err_o can never set.

Decomposition:
- Shared package mux_pkg: default WIDTH constant, state enum {EMPTY, ONE, FULL}, and a function sat_sel(sel, num_in) returning eff_sel.
- One sub-module, mux_sel_comb: pure combinational NUM_IN-way select with saturation. It is instantiated once on the input path; the skid holds post-select data.

Test Plan:
- Reset mid-FULL: fill both entries, assert rst_i=0 asynchronously -> out_valid_o=0, in_ready_o=1, out_data_o=0 immediately, without waiting for a clock edge.
- Stream with NUM_IN=4, out_ready_i=1, inputs 0x11,0x22,0x33,0x44, sel 0..3 on consecutive cycles -> out_data_o 0x11,0x22,0x33,0x44 one cycle later; in_ready_o stays 1.
- Backpressure: out_ready_i=0, accept A=0xAAAA then B=0xBBBB -> in_ready_o=0 after the second accept, out_data_o held at 0xAAAA. Release out_ready_i -> A then B, and in_ready_o=1 the cycle after A emits.
- Saturation with NUM_IN=3, inputs {0x1,0x2,0x3}, sel_i=3 -> out_data_o=0x3, out_sel_o=2. With MUX_SKID_SELCHK_EN, err_o=1 and stays 1 after further legal selects.
- Simultaneous accept+emit in ONE state over 100 random cycles with random out_ready_i -> scoreboard sees an in-order, lossless, duplicate-free output sequence.
- WIDTH=8, NUM_IN=2: sel_i=1, input1=0xFF -> out_data_o=0xFF, with no sign extension beyond 8 bits.
